// File: rtl/if_fetch_queue.sv
// if_fetch_queue: instruction fetch unit with a small prefetch FIFO.
// Issues word reads to instruction memory while FIFO credit remains, queues
// the returning instructions with their PC+4 and hands them to decode.
// A redirect flushes the queue and restarts fetch at a new address; fetching
// stops after HALT_INSTR is received, until the next redirect or reset.
// Optional build macro FETCH_BYPASS_EN: a response arriving at an empty FIFO
// is presented to decode in the same cycle (one cycle less latency).
module if_fetch_queue #(
  parameter int                ADDR_W     = 32,
  parameter int                DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [31:0]       HALT_INSTR = 32'hff000000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         imem_rd_en_o,
  output logic [ADDR_W-1:0]            imem_addr_o,
  input  logic [31:0]                  imem_rdata_i,
  input  logic                         redirect_i,
  input  logic [ADDR_W-1:0]            redirect_pc_i,
  input  logic                         id_ready_i,
  output logic                         id_valid_o,
  output logic [31:0]                  id_instr_o,
  output logic [ADDR_W-1:0]            id_pc_plus4_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         halted_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W:0]    DEPTH_C = (CNT_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] FOUR    = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_M = ~(ADDR_W'(3));

  logic [ADDR_W-1:0] pc_reg;
  logic              inflight_reg;      // a read was issued last cycle
  logic [ADDR_W-1:0] inflight_pc4_reg;  // PC+4 of that read
  logic              halted_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [31:0]       instr_mem [DEPTH];
  logic [ADDR_W-1:0] pc4_mem   [DEPTH];

  logic              issue;
  logic              resp_ok;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic              halt_hit;
  logic [CNT_W:0]    occupancy;
  logic [ADDR_W-1:0] pc_plus4;

  // Fetch credit, response acceptance and halt detection.
  always_comb begin
    occupancy  = {1'b0, count_reg} + {{CNT_W{1'b0}}, inflight_reg};
    fifo_empty = (count_reg == '0);
    pc_plus4   = pc_reg + FOUR;
    // The in-flight response already owns a slot, so it is part of the credit.
    issue      = rst_n & ~redirect_i & ~halted_reg & (occupancy < DEPTH_C);
    // Responses are dropped during a redirect and once halted (younger than the halt).
    resp_ok    = rst_n & inflight_reg & ~redirect_i & ~halted_reg;
    halt_hit   = resp_ok & (imem_rdata_i == HALT_INSTR);
    pop        = ~fifo_empty & id_ready_i;
  end

  // Decode-side outputs: FIFO head, or the arriving response when bypassing.
  always_comb begin
    id_valid_o    = ~fifo_empty;
    id_instr_o    = '0;
    id_pc_plus4_o = '0;
    push          = resp_ok;
    if (!fifo_empty) begin
      id_instr_o    = instr_mem[rd_ptr_reg];
      id_pc_plus4_o = pc4_mem[rd_ptr_reg];
    end
`ifdef FETCH_BYPASS_EN
    else if (resp_ok) begin
      id_valid_o    = 1'b1;
      id_instr_o    = imem_rdata_i;
      id_pc_plus4_o = inflight_pc4_reg;
      push          = ~id_ready_i;
    end
`endif
  end

  assign imem_rd_en_o = issue;
  assign imem_addr_o  = pc_reg >> 2;
  assign count_o      = count_reg;
  assign halted_o     = halted_reg;

  // Fetch PC, in-flight tracking, halt flag and FIFO pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg           <= RESET_PC;
      inflight_reg     <= 1'b0;
      inflight_pc4_reg <= '0;
      halted_reg       <= 1'b0;
      count_reg        <= '0;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
    end else begin
      inflight_reg <= issue;
      if (issue) begin
        pc_reg           <= pc_plus4;
        inflight_pc4_reg <= pc_plus4;
      end
      if (redirect_i) begin
        pc_reg     <= redirect_pc_i & ALIGN_M;
        halted_reg <= 1'b0;
        count_reg  <= '0;
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
      end else begin
        halted_reg <= halted_reg | halt_hit;
        if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        case ({push, pop})
          2'b10:   count_reg <= count_reg + CNT_W'(1);
          2'b01:   count_reg <= count_reg - CNT_W'(1);
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  // Entry storage; contents are only observed through a valid head pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_reg] <= imem_rdata_i;
      pc4_mem[wr_ptr_reg]   <= inflight_pc4_reg;
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: randomized + directed bench for if_fetch_queue with a
// queue-based reference model and cycle logs for literal scenario checks.
module tb_if_fetch_queue;
  localparam int          DEPTH = 4;
  localparam logic [31:0] HALT  = 32'hff000000;
  localparam int          LOGN  = 8192;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_rd_en_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_ready_i;
  logic        id_valid_o;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_plus4_o;
  logic [2:0]  count_o;
  logic        halted_o;

  always #5 clk = ~clk;

  if_fetch_queue #(.ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .HALT_INSTR(HALT)) dut (
    .clk(clk), .rst_n(rst_n), .imem_rd_en_o(imem_rd_en_o), .imem_addr_o(imem_addr_o),
    .imem_rdata_i(imem_rdata_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .id_ready_i(id_ready_i), .id_valid_o(id_valid_o), .id_instr_o(id_instr_o),
    .id_pc_plus4_o(id_pc_plus4_o), .count_o(count_o), .halted_o(halted_o)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit cmp_en   = 1'b0;
  bit          halt_on = 1'b0;
  logic [31:0] halt_waddr = 32'h0;

  // Per-cycle log of DUT outputs (sampled mid-cycle) and delivered stream.
  logic        log_rden  [LOGN];
  logic [31:0] log_addr  [LOGN];
  logic [31:0] log_count [LOGN];
  logic        log_valid [LOGN];
  logic [31:0] log_instr [LOGN];
  logic [31:0] log_pc4   [LOGN];
  logic        log_halt  [LOGN];
  logic [31:0] dl_instr[$];
  logic [31:0] dl_pc4[$];

  // Reference model state: queued entries, fetch PC, outstanding read, halt.
  logic [31:0] mq_instr[$];
  logic [31:0] mq_pc4[$];
  logic [31:0] m_pc     = 32'h0;
  logic [31:0] m_fl_pc  = 32'h0;
  bit          m_fl     = 1'b0;
  bit          m_halted = 1'b0;

  typedef struct {
    bit          issue;
    bit          resp;
    bit          byp;
    bit          valid;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] rinstr;
  } exp_t;

  // Memory contents: word k holds k, except an optional halt word.
  function automatic logic [31:0] mem_word(input logic [31:0] w);
    return (halt_on && w == halt_waddr) ? HALT : w;
  endfunction

  // Expected outputs for the current cycle from model state and current inputs.
  function automatic exp_t model_outputs();
    exp_t e;
    int   n = mq_instr.size();
    e.issue  = rst_n && !redirect_i && !m_halted && (n + int'(m_fl) < DEPTH);
    e.resp   = rst_n && m_fl && !redirect_i && !m_halted;
    e.rinstr = mem_word(m_fl_pc >> 2);
    e.byp    = 1'b0;
`ifdef FETCH_BYPASS_EN
    e.byp    = e.resp && (n == 0);
`endif
    e.valid  = (n != 0) || e.byp;
    e.instr  = (n != 0) ? mq_instr[0] : e.rinstr;
    e.pc4    = (n != 0) ? mq_pc4[0] : m_fl_pc + 32'd4;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Model advances on each rising edge using the inputs of the ending cycle.
  always @(posedge clk) begin
    exp_t e;
    bit   took;
    e = model_outputs();
    if (!rst_n || redirect_i) begin
      mq_instr.delete();
      mq_pc4.delete();
      m_fl     = 1'b0;
      m_halted = 1'b0;
      m_pc     = !rst_n ? 32'h0 : (redirect_pc_i & ~32'd3);
    end else begin
      took = e.valid && id_ready_i;
      if (took && mq_instr.size() != 0) begin
        void'(mq_instr.pop_front());
        void'(mq_pc4.pop_front());
      end
      if (e.resp && !(e.byp && took)) begin
        mq_instr.push_back(e.rinstr);
        mq_pc4.push_back(m_fl_pc + 32'd4);
      end
      if (e.resp && e.rinstr == HALT) m_halted = 1'b1;
      m_fl = e.issue;
      if (e.issue) begin
        m_fl_pc = m_pc;
        m_pc    = m_pc + 32'd4;
      end
    end
    cyc++;
  end

  // Compare process: DUT outputs against the model every cycle, plus logging.
  always @(negedge clk) begin
    exp_t e;
    if (cmp_en) begin
      e = model_outputs();
      chk("rd_en", 32'(imem_rd_en_o), 32'(e.issue));
      if (e.issue) chk("addr", imem_addr_o, m_pc >> 2);
      chk("valid", 32'(id_valid_o), 32'(e.valid));
      if (e.valid) begin
        chk("instr", id_instr_o, e.instr);
        chk("pc4", id_pc_plus4_o, e.pc4);
      end
      chk("count", 32'(count_o), 32'(mq_instr.size()));
      chk("halted", 32'(halted_o), 32'(m_halted));
      if (id_valid_o && id_ready_i && rst_n) begin
        dl_instr.push_back(id_instr_o);
        dl_pc4.push_back(id_pc_plus4_o);
      end
    end
    if (cyc < LOGN) begin
      log_rden[cyc]  <= imem_rd_en_o;
      log_addr[cyc]  <= imem_addr_o;
      log_count[cyc] <= 32'(count_o);
      log_valid[cyc] <= id_valid_o;
      log_instr[cyc] <= id_instr_o;
      log_pc4[cyc]   <= id_pc_plus4_o;
      log_halt[cyc]  <= halted_o;
    end
  end

  // Drive one cycle of inputs, then answer the read the DUT issued in it.
  task automatic apply(input bit r, input bit rd, input logic [31:0] rpc, input bit rdy);
    rst_n = r; redirect_i = rd; redirect_pc_i = rpc; id_ready_i = rdy;
    @(posedge clk); #1;
    if (log_rden[cyc-1] === 1'b1) imem_rdata_i = mem_word(log_addr[cyc-1]);
    else imem_rdata_i = $urandom & 32'h7fffffff;
  endtask

  // Delivered entry k counted from base; a missing entry reads as a sentinel.
  task automatic chk_dl(input string nm, input int base, input int k,
                        input logic [31:0] ei, input logic [31:0] ep);
    chk({nm, "_instr"}, (dl_instr.size() > base + k) ? dl_instr[base+k] : 32'hdeadbeef, ei);
    chk({nm, "_pc4"},   (dl_pc4.size()   > base + k) ? dl_pc4[base+k]   : 32'hdeadbeef, ep);
  endtask

  initial begin
    int t0, tr, rc, rr, base, s, fv, bad;
    rst_n = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0; id_ready_i = 1'b0; imem_rdata_i = '0;
    @(posedge clk); #1;
    cmp_en = 1'b1;

    // Reset values, then straight-line fetch with decode always ready.
    apply(0, 0, 0, 1);
    tr = cyc;
    apply(0, 0, 0, 1);
    chk("rst_count", log_count[tr], 32'd0);
    chk("rst_valid", 32'(log_valid[tr]), 32'd0);
    chk("rst_rden", 32'(log_rden[tr]), 32'd0);
    chk("rst_halted", 32'(log_halt[tr]), 32'd0);
    chk("rst_instr", log_instr[tr], 32'd0);
    chk("rst_pc4", log_pc4[tr], 32'd0);
    base = dl_instr.size(); t0 = cyc;
    repeat (8) apply(1, 0, 0, 1);
    chk("A_rden0", 32'(log_rden[t0]), 32'd1);
    chk("A_addr0", log_addr[t0], 32'd0);
    chk("A_addr1", log_addr[t0+1], 32'd1);
    chk("A_addr2", log_addr[t0+2], 32'd2);
    fv = -1;
    for (int i = t0 + 7; i >= t0; i--) if (log_valid[i] === 1'b1) fv = i - t0;
`ifdef FETCH_BYPASS_EN
    chk("A_first_valid", 32'(fv), 32'd1);
`else
    chk("A_first_valid", 32'(fv), 32'd2);
`endif
    chk_dl("A_d0", base, 0, 32'd0, 32'd4);
    chk_dl("A_d1", base, 1, 32'd1, 32'd8);
    chk_dl("A_d2", base, 2, 32'd2, 32'd12);

    // Decode stalled for 10 cycles: occupancy saturates, then drains in order.
    apply(0, 0, 0, 0);
    base = dl_instr.size(); t0 = cyc;
    repeat (10) apply(1, 0, 0, 0);
    s = 0;
    for (int i = t0; i < t0 + 10; i++) s += int'(log_rden[i]);
    chk("B_issues", 32'(s), 32'd4);
    chk("B_count", log_count[t0+9], 32'd4);
    chk("B_rden_off", 32'(log_rden[t0+9]), 32'd0);
    repeat (10) apply(1, 0, 0, 1);
    for (int k = 0; k < 6; k++) chk_dl("B_d", base, k, 32'(k), 32'(4*k + 4));

    // Redirect with three entries queued and one read in flight.
    apply(0, 0, 0, 0);
    base = dl_instr.size();
    repeat (4) apply(1, 0, 0, 0);
    rc = cyc;
    apply(1, 1, 32'h103, 0);
    repeat (8) apply(1, 0, 0, 1);
    chk("C_count_before", log_count[rc], 32'd3);
    chk("C_count_after", log_count[rc+1], 32'd0);
    chk("C_rden", 32'(log_rden[rc+1]), 32'd1);
    chk("C_addr", log_addr[rc+1], 32'h40);
    chk_dl("C_d0", base, 0, 32'h40, 32'h104);
    bad = 0;
    for (int i = base; i < dl_instr.size(); i++) if (dl_instr[i] < 32'h40) bad++;
    chk("C_killed_seen", 32'(bad), 32'd0);

    // Halt word at byte 0x8, then redirect to 0x20.
    halt_on = 1'b1; halt_waddr = 32'd2;
    apply(0, 0, 0, 1);
    base = dl_instr.size(); t0 = cyc;
    repeat (12) apply(1, 0, 0, 1);
    chk("D_ndeliv", 32'(dl_instr.size() - base), 32'd3);
    chk_dl("D_d0", base, 0, 32'd0, 32'd4);
    chk_dl("D_d1", base, 1, 32'd1, 32'd8);
    chk_dl("D_d2", base, 2, HALT, 32'd12);
    chk("D_halted", 32'(log_halt[t0+11]), 32'd1);
    s = 0;
    for (int i = t0 + 6; i < t0 + 12; i++) s += int'(log_rden[i]);
    chk("D_no_fetch", 32'(s), 32'd0);
    rc = cyc;
    apply(1, 1, 32'h20, 1);
    repeat (6) apply(1, 0, 0, 1);
    chk("D_unhalt", 32'(log_halt[rc+1]), 32'd0);
    chk("D_resume_rden", 32'(log_rden[rc+1]), 32'd1);
    chk("D_resume_addr", log_addr[rc+1], 32'h8);
    chk_dl("D_d3", base, 3, 32'h8, 32'h24);
    halt_on = 1'b0;

    // Address wrap at the top of the 32-bit space.
    apply(0, 0, 0, 1);
    base = dl_instr.size(); rc = cyc;
    apply(1, 1, 32'hfffffff8, 1);
    repeat (8) apply(1, 0, 0, 1);
    chk("E_addr0", log_addr[rc+1], 32'h3ffffffe);
    chk("E_addr1", log_addr[rc+2], 32'h3fffffff);
    chk("E_addr2", log_addr[rc+3], 32'h0);
    chk_dl("E_d0", base, 0, 32'h3ffffffe, 32'hfffffffc);
    chk_dl("E_d1", base, 1, 32'h3fffffff, 32'h0);
    chk_dl("E_d2", base, 2, 32'h0, 32'h4);

    // One-cycle reset with two entries queued and one in flight.
    apply(0, 0, 0, 0);
    apply(1, 1, 32'h100, 0);
    repeat (3) apply(1, 0, 0, 0);
    rr = cyc;
    apply(0, 0, 0, 0);
    base = dl_instr.size(); t0 = cyc;
    repeat (6) apply(1, 0, 0, 1);
    chk("F_count_before", log_count[rr], 32'd2);
    chk("F_rden", 32'(log_rden[t0]), 32'd1);
    chk("F_addr", log_addr[t0], 32'h0);
    chk("F_count", log_count[t0], 32'd0);
    chk("F_valid", 32'(log_valid[t0]), 32'd0);
    chk("F_instr", log_instr[t0], 32'd0);
    chk("F_pc4", log_pc4[t0], 32'd0);
    chk("F_halted", 32'(log_halt[t0]), 32'd0);
    chk_dl("F_d0", base, 0, 32'd0, 32'd4);
    bad = 0;
    for (int i = base; i < dl_instr.size(); i++) if (dl_instr[i] >= 32'h40) bad++;
    chk("F_stale_seen", 32'(bad), 32'd0);

    // Randomized traffic checked cycle by cycle against the model.
    halt_on = 1'b1; halt_waddr = 32'h50;
    for (int i = 0; i < 1500; i++) begin
      bit          r, rd, rdy;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 99) != 0);
      rd  = ($urandom_range(0, 99) < 6);
      rdy = ($urandom_range(0, 99) < 70);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hfffffff0 + 32'($urandom_range(0, 15)))
                                        : 32'($urandom_range(0, 511));
      apply(r, rd, rpc, rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
